// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a byte-wide Bambu-style master memory port.
// A grant is held until the memory strobes DataRdy or the watchdog expires.
module mem_port_arbiter #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 8,
  parameter int SIZE_W  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_oe_ram,
  input  logic              m0_we_ram,
  input  logic [ADDR_W-1:0] m0_addr_ram,
  input  logic [DATA_W-1:0] m0_Wdata_ram,
  input  logic [SIZE_W-1:0] m0_data_ram_size,
  output logic [DATA_W-1:0] m0_Rdata_ram,
  output logic              m0_DataRdy,
  input  logic              m1_oe_ram,
  input  logic              m1_we_ram,
  input  logic [ADDR_W-1:0] m1_addr_ram,
  input  logic [DATA_W-1:0] m1_Wdata_ram,
  input  logic [SIZE_W-1:0] m1_data_ram_size,
  output logic [DATA_W-1:0] m1_Rdata_ram,
  output logic              m1_DataRdy,
  output logic              Mout_oe_ram,
  output logic              Mout_we_ram,
  output logic [ADDR_W-1:0] Mout_addr_ram,
  output logic [DATA_W-1:0] Mout_Wdata_ram,
  output logic [SIZE_W-1:0] Mout_data_ram_size,
  input  logic [DATA_W-1:0] M_Rdata_ram,
  input  logic              M_DataRdy,
  output logic [1:0]        grant,
  output logic              err_timeout,
  output logic              err_conflict
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_conflict_q, err_conflict_d;

  logic              req0_s, req1_s;
  logic              conflict_s;
  logic              busy_s;
  logic              own_req_s;

  assign req0_s     = m0_oe_ram | m0_we_ram;
  assign req1_s     = m1_oe_ram | m1_we_ram;
  assign conflict_s = (m0_oe_ram & m0_we_ram) | (m1_oe_ram & m1_we_ram);
  assign busy_s     = (state_q == BUSY);
  assign own_req_s  = owner_q ? req1_s : req0_s;

  // State, ownership and sticky error registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      last_q         <= 1'b1;
      wdog_q         <= '0;
      err_timeout_q  <= 1'b0;
      err_conflict_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_q         <= last_d;
      wdog_q         <= wdog_d;
      err_timeout_q  <= err_timeout_d;
      err_conflict_q <= err_conflict_d;
    end
  end

  // Arbitration, completion and watchdog next-state logic.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    wdog_d         = wdog_q;
    err_timeout_d  = err_timeout_q;
    err_conflict_d = err_conflict_q | conflict_s;
    case (state_q)
      IDLE: begin
        if (req0_s | req1_s) begin
          state_d = BUSY;
          wdog_d  = '0;
          // Ties go to whichever requester was not served last.
          if (req0_s & req1_s) begin
            owner_d = ~last_q;
          end else begin
            owner_d = req1_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (M_DataRdy) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (wdog_q == WDOG_LAST) begin
          state_d       = IDLE;
          last_d        = owner_q;
          err_timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory-side mux and requester-side return paths; all zero unless owned.
  always_comb begin
    Mout_oe_ram        = 1'b0;
    Mout_we_ram        = 1'b0;
    Mout_addr_ram      = '0;
    Mout_Wdata_ram     = '0;
    Mout_data_ram_size = '0;
    m0_Rdata_ram       = '0;
    m0_DataRdy         = 1'b0;
    m1_Rdata_ram       = '0;
    m1_DataRdy         = 1'b0;
    grant              = 2'b00;
    if (busy_s) begin
      if (owner_q) begin
        grant        = 2'b10;
        m1_Rdata_ram = M_Rdata_ram;
        m1_DataRdy   = M_DataRdy;
      end else begin
        grant        = 2'b01;
        m0_Rdata_ram = M_Rdata_ram;
        m0_DataRdy   = M_DataRdy;
      end
      // An owner that withdrew its request mid-transaction sees zeros forwarded.
      if (own_req_s) begin
        if (owner_q) begin
          Mout_oe_ram        = m1_oe_ram;
          Mout_we_ram        = m1_we_ram;
          Mout_addr_ram      = m1_addr_ram;
          Mout_Wdata_ram     = m1_Wdata_ram;
          Mout_data_ram_size = m1_data_ram_size;
        end else begin
          Mout_oe_ram        = m0_oe_ram;
          Mout_we_ram        = m0_we_ram;
          Mout_addr_ram      = m0_addr_ram;
          Mout_Wdata_ram     = m0_Wdata_ram;
          Mout_data_ram_size = m0_data_ram_size;
        end
      end else begin
        Mout_oe_ram = 1'b0;
      end
    end else begin
      grant = 2'b00;
    end
  end

  assign err_timeout  = err_timeout_q;
  assign err_conflict = err_conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small latency-2 byte memory model.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 8;
  localparam int SIZE_W  = 4;
  localparam int TIMEOUT = 16;
  localparam int MEM_LAT = 2;

  logic              clock;
  logic              reset;
  logic              m0_oe_ram, m0_we_ram;
  logic [ADDR_W-1:0] m0_addr_ram;
  logic [DATA_W-1:0] m0_Wdata_ram;
  logic [SIZE_W-1:0] m0_data_ram_size;
  logic [DATA_W-1:0] m0_Rdata_ram;
  logic              m0_DataRdy;
  logic              m1_oe_ram, m1_we_ram;
  logic [ADDR_W-1:0] m1_addr_ram;
  logic [DATA_W-1:0] m1_Wdata_ram;
  logic [SIZE_W-1:0] m1_data_ram_size;
  logic [DATA_W-1:0] m1_Rdata_ram;
  logic              m1_DataRdy;
  logic              Mout_oe_ram, Mout_we_ram;
  logic [ADDR_W-1:0] Mout_addr_ram;
  logic [DATA_W-1:0] Mout_Wdata_ram;
  logic [SIZE_W-1:0] Mout_data_ram_size;
  logic [DATA_W-1:0] M_Rdata_ram;
  logic              M_DataRdy;
  logic [1:0]        grant;
  logic              err_timeout;
  logic              err_conflict;

  int total = 0;
  int bad   = 0;

  logic              mem_en;
  logic [7:0]        mem [0:8191];
  logic [8191:0]     wr_valid;
  int                cnt;

  logic [7:0]        rd;
  int                n;
  int                busy_n;
  logic              rdy_seen;
  logic [1:0]        prev;
  logic [1:0]        seq [6];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SIZE_W (SIZE_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .m0_oe_ram         (m0_oe_ram),
    .m0_we_ram         (m0_we_ram),
    .m0_addr_ram       (m0_addr_ram),
    .m0_Wdata_ram      (m0_Wdata_ram),
    .m0_data_ram_size  (m0_data_ram_size),
    .m0_Rdata_ram      (m0_Rdata_ram),
    .m0_DataRdy        (m0_DataRdy),
    .m1_oe_ram         (m1_oe_ram),
    .m1_we_ram         (m1_we_ram),
    .m1_addr_ram       (m1_addr_ram),
    .m1_Wdata_ram      (m1_Wdata_ram),
    .m1_data_ram_size  (m1_data_ram_size),
    .m1_Rdata_ram      (m1_Rdata_ram),
    .m1_DataRdy        (m1_DataRdy),
    .Mout_oe_ram       (Mout_oe_ram),
    .Mout_we_ram       (Mout_we_ram),
    .Mout_addr_ram     (Mout_addr_ram),
    .Mout_Wdata_ram    (Mout_Wdata_ram),
    .Mout_data_ram_size(Mout_data_ram_size),
    .M_Rdata_ram       (M_Rdata_ram),
    .M_DataRdy         (M_DataRdy),
    .grant             (grant),
    .err_timeout       (err_timeout),
    .err_conflict      (err_conflict)
  );

  // Unwritten locations read back as a fixed address hash.
  function automatic logic [7:0] fill(input logic [12:0] a);
    return 8'hA5 ^ a[7:0] ^ {3'b000, a[12:8]} ^ 8'h06;
  endfunction

  // Memory model: DataRdy MEM_LAT cycles after a request appears.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt         <= 0;
      M_DataRdy   <= 1'b0;
      M_Rdata_ram <= 8'h00;
      wr_valid    <= '0;
    end else begin
      M_DataRdy <= 1'b0;
      if (mem_en && (Mout_oe_ram || Mout_we_ram) && !M_DataRdy) begin
        if (cnt == MEM_LAT - 1) begin
          cnt         <= 0;
          M_DataRdy   <= 1'b1;
          M_Rdata_ram <= wr_valid[Mout_addr_ram] ? mem[Mout_addr_ram] : fill(Mout_addr_ram);
          if (Mout_we_ram) begin
            mem[Mout_addr_ram]      <= Mout_Wdata_ram;
            wr_valid[Mout_addr_ram] <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1;
        end
      end else begin
        cnt <= 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    check("rst_grant", {30'd0, grant}, 32'h0);
    check("rst_mout_oe", {31'd0, Mout_oe_ram}, 32'h0);
    check("rst_err_timeout", {31'd0, err_timeout}, 32'h0);
    check("rst_err_conflict", {31'd0, err_conflict}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_rdy(input int who, input int bound, output logic [7:0] data);
    logic seen;
    seen = 1'b0;
    data = 8'h00;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clock);
      if ((who == 0) ? m0_DataRdy : m1_DataRdy) begin
        seen = 1'b1;
        data = (who == 0) ? m0_Rdata_ram : m1_Rdata_ram;
        check("rdy_peer_quiet", {31'd0, (who == 0) ? m1_DataRdy : m0_DataRdy}, 32'h0);
      end
    end
    check("rdy_seen", {31'd0, seen}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    mem_en = 1'b1;
    m0_oe_ram = 1'b0; m0_we_ram = 1'b0; m0_addr_ram = '0; m0_Wdata_ram = '0; m0_data_ram_size = 4'd8;
    m1_oe_ram = 1'b0; m1_we_ram = 1'b0; m1_addr_ram = '0; m1_Wdata_ram = '0; m1_data_ram_size = 4'd8;
    for (int k = 0; k < 6; k++) seq[k] = 2'b00;
    do_reset();

    // single read from m0
    m0_oe_ram = 1'b1; m0_addr_ram = 13'h0600;
    #1;
    check("t1_idle_oe", {31'd0, Mout_oe_ram}, 32'h0);
    @(negedge clock);
    check("t1_grant", {30'd0, grant}, 32'h1);
    check("t1_mout_oe", {31'd0, Mout_oe_ram}, 32'h1);
    check("t1_mout_addr", {19'd0, Mout_addr_ram}, 32'h0600);
    check("t1_mout_size", {28'd0, Mout_data_ram_size}, 32'h8);
    wait_rdy(0, 10, rd);
    check("t1_rdata", {24'd0, rd}, 32'hA5);
    check("t1_m1_rdata", {24'd0, m1_Rdata_ram}, 32'h0);
    m0_oe_ram = 1'b0; m0_addr_ram = '0;
    @(negedge clock);
    check("t1_back_idle", {30'd0, grant}, 32'h0);

    // simultaneous write from m0 and read from m1
    do_reset();
    m0_we_ram = 1'b1; m0_addr_ram = 13'h0200; m0_Wdata_ram = 8'h3C;
    m1_oe_ram = 1'b1; m1_addr_ram = 13'h0400; m1_Wdata_ram = 8'h99;
    @(negedge clock);
    check("t2_grant_m0", {30'd0, grant}, 32'h1);
    check("t2_mout_we", {31'd0, Mout_we_ram}, 32'h1);
    check("t2_mout_oe", {31'd0, Mout_oe_ram}, 32'h0);
    check("t2_mout_wdata", {24'd0, Mout_Wdata_ram}, 32'h3C);
    wait_rdy(0, 10, rd);
    m0_we_ram = 1'b0; m0_addr_ram = '0; m0_Wdata_ram = '0;
    @(negedge clock);
    check("t2_gap", {30'd0, grant}, 32'h0);
    @(negedge clock);
    check("t2_grant_m1", {30'd0, grant}, 32'h2);
    check("t2_mout_addr", {19'd0, Mout_addr_ram}, 32'h0400);
    check("t2_mout_wdata_m1", {24'd0, Mout_Wdata_ram}, 32'h99);
    check("t2_mem_0200", {24'd0, mem[13'h0200]}, 32'h3C);
    wait_rdy(1, 10, rd);
    check("t2_m1_rdata", {24'd0, rd}, 32'hA7);
    m1_oe_ram = 1'b0; m1_addr_ram = '0; m1_Wdata_ram = '0;

    // continuous requests alternate owners
    do_reset();
    m0_oe_ram = 1'b1; m0_addr_ram = 13'h0600;
    m1_oe_ram = 1'b1; m1_addr_ram = 13'h0400;
    n = 0; prev = 2'b00;
    for (int i = 0; i < 200 && n < 6; i++) begin
      @(negedge clock);
      if (grant != 2'b00 && prev == 2'b00) begin
        seq[n] = grant;
        n++;
      end
      prev = grant;
    end
    check("t3_count", n, 32'd6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t3_grant%0d", k), {30'd0, seq[k]}, (k % 2 == 0) ? 32'h1 : 32'h2);
    end
    wait_rdy(1, 10, rd);
    m0_oe_ram = 1'b0; m1_oe_ram = 1'b0;

    // watchdog expiry with a silent memory
    do_reset();
    mem_en = 1'b0;
    m0_oe_ram = 1'b1; m0_addr_ram = 13'h0020;
    busy_n = 0; rdy_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (grant == 2'b01) busy_n++;
      if (m0_DataRdy) rdy_seen = 1'b1;
    end
    check("t4_busy_cycles", busy_n, 32'd16);
    check("t4_no_err_yet", {31'd0, err_timeout}, 32'h0);
    @(negedge clock);
    check("t4_err_timeout", {31'd0, err_timeout}, 32'h1);
    check("t4_idle", {30'd0, grant}, 32'h0);
    check("t4_no_rdy", {31'd0, rdy_seen | m0_DataRdy}, 32'h0);
    m1_oe_ram = 1'b1; m1_addr_ram = 13'h0400; mem_en = 1'b1;
    @(negedge clock);
    check("t4_grant_m1", {30'd0, grant}, 32'h2);
    wait_rdy(1, 10, rd);
    check("t4_m1_rdata", {24'd0, rd}, 32'hA7);
    m1_oe_ram = 1'b0; m1_addr_ram = '0;
    @(negedge clock);
    @(negedge clock);
    check("t4_grant_m0", {30'd0, grant}, 32'h1);
    wait_rdy(0, 10, rd);
    check("t4_m0_rdata", {24'd0, rd}, 32'h83);
    m0_oe_ram = 1'b0; m0_addr_ram = '0;
    @(negedge clock);
    check("t4_err_sticky", {31'd0, err_timeout}, 32'h1);

    // oe and we together from m1
    check("t5_no_conflict", {31'd0, err_conflict}, 32'h0);
    m1_oe_ram = 1'b1; m1_we_ram = 1'b1; m1_addr_ram = 13'h0010; m1_Wdata_ram = 8'h55;
    @(negedge clock);
    check("t5_conflict", {31'd0, err_conflict}, 32'h1);
    check("t5_grant", {30'd0, grant}, 32'h2);
    check("t5_fwd_both", {30'd0, Mout_oe_ram, Mout_we_ram}, 32'h3);
    wait_rdy(1, 10, rd);
    m1_oe_ram = 1'b0; m1_we_ram = 1'b0; m1_addr_ram = '0; m1_Wdata_ram = '0;
    @(negedge clock);
    check("t5_mem_0010", {24'd0, mem[13'h0010]}, 32'h55);
    repeat (3) @(negedge clock);
    check("t5_conflict_sticky", {31'd0, err_conflict}, 32'h1);

    // reset in the middle of a transaction
    do_reset();
    m1_oe_ram = 1'b1; m1_addr_ram = 13'h0400;
    @(negedge clock);
    check("t6_busy", {30'd0, grant}, 32'h2);
    check("t6_busy_oe", {31'd0, Mout_oe_ram}, 32'h1);
    reset = 1'b0;
    #1;
    check("t6_async_oe", {30'd0, Mout_oe_ram, Mout_we_ram}, 32'h0);
    check("t6_async_grant", {30'd0, grant}, 32'h0);
    check("t6_async_rdy", {31'd0, m1_DataRdy}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    m0_oe_ram = 1'b1; m0_addr_ram = 13'h0600;
    @(negedge clock);
    check("t6_m0_priority", {30'd0, grant}, 32'h1);
    wait_rdy(0, 10, rd);
    check("t6_m0_rdata", {24'd0, rd}, 32'hA5);
    m0_oe_ram = 1'b0; m0_addr_ram = '0;
    wait_rdy(1, 10, rd);
    check("t6_m1_rdata", {24'd0, rd}, 32'hA7);
    m1_oe_ram = 1'b0; m1_addr_ram = '0;
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one Bambu-style byte-wide master memory port (oe/we/addr/Wdata/data_ram_size with Rdata/DataRdy) between two HLS master requesters.
- Sits between two accelerator top-level Mout_* interfaces and the single M_* port of the testbench/off-chip memory model.
- Round-robin arbitration; each grant is locked until the memory completes the transaction.
- Provides a watchdog and a protocol-violation flag for simulation triage.

Parameters:
- ADDR_W, 13, address width of all ports
- DATA_W, 8, data width of all ports
- SIZE_W, 4, data_ram_size width
- TIMEOUT, 1024, max cycles a grant may wait for DataRdy (>=2)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- m0_oe_ram  in  1  requester 0 read request
- m0_we_ram  in  1  requester 0 write request
- m0_addr_ram  in  ADDR_W  requester 0 address
- m0_Wdata_ram  in  DATA_W  requester 0 write data
- m0_data_ram_size  in  SIZE_W  requester 0 access size in bits
- m0_Rdata_ram  out  DATA_W  read data to requester 0
- m0_DataRdy  out  1  completion strobe to requester 0
- m1_* (oe, we, addr, Wdata, data_ram_size, Rdata, DataRdy)  same as m0_*, for requester 1
- Mout_oe_ram, Mout_we_ram  out  1  to memory
- Mout_addr_ram  out  ADDR_W  to memory
- Mout_Wdata_ram  out  DATA_W  to memory
- Mout_data_ram_size  out  SIZE_W  to memory
- M_Rdata_ram  in  DATA_W  from memory
- M_DataRdy  in  1  from memory, one-cycle completion strobe
- grant  out  2  one-hot current owner (00 = none)
- err_timeout  out  1  sticky watchdog flag
- err_conflict  out  1  sticky flag: a requester drove oe and we together

Behaviour:
- Request: req_i = mi_oe_ram | mi_we_ram. Requesters hold all signals stable until they see mi_DataRdy.
- States: IDLE and BUSY. Registers: owner (1 bit), last (1 bit), wdog counter (clog2(TIMEOUT) bits), err flags.
- Reset (reset=0, async): state=IDLE, last=1 (requester 0 wins first), wdog=0, errors=0.
  - All outputs are 0 while in reset or IDLE: Mout_*, m*_Rdata_ram, m*_DataRdy, grant.
- IDLE:
  - One request pending: grant it.
  - Both pending: grant the requester != last.
  - On grant: BUSY next cycle, wdog=0.
  - No memory signals are driven in IDLE, so arbitration latency is 1 cycle.
- BUSY:
  - Mout_* is combinationally muxed from the owner's inputs.
  - grant = one-hot(owner). The non-owner's outputs stay 0.
- Completion: M_DataRdy=1 in BUSY.
  - Owner's DataRdy=1 and Rdata=M_Rdata_ram in the same cycle, combinational passthrough.
  - Next cycle: IDLE, last=owner.
  - There is always at least one IDLE cycle between grants. The just-served requester loses to a pending peer.
- M_DataRdy in IDLE is ignored and never forwarded.
- Owner drops its request in BUSY without DataRdy (protocol error): the arbiter stays BUSY, driving zeros, until DataRdy or timeout.
- Watchdog: wdog increments each BUSY cycle without M_DataRdy.
  - If wdog==TIMEOUT-1 and no DataRdy: err_timeout<=1, state<=IDLE, last=owner, no DataRdy to the owner.
  - DataRdy in that same cycle takes priority: normal completion, no error.
- Conflict: any cycle with mi_oe_ram & mi_we_ram both high sets err_conflict<=1, whether or not i is granted.
  - The request is still arbitrated and forwarded as-is.
- Error flags clear only on reset.
- Reset asserted mid-BUSY: Mout_oe/we drop immediately (async). The in-flight transaction is abandoned and the arbiter returns to IDLE with last=1.
- Memory read latency is not assumed. Any latency >=1 cycle up to TIMEOUT-1 works.

Test Plan:
- After reset, m0 read addr 0x0600 alone, memory DataRdy 2 cycles after Mout_oe → grant=01 one cycle after request; Mout_addr_ram=0x0600; m0_DataRdy with the returned byte 0xA5; m1 outputs stay 0.
- Both request at the same cycle from reset (m0 write 0x0200 data 0x3C, m1 read 0x0400) → m0 served first, then one IDLE cycle, then m1; memory byte at 0x0200 = 0x3C.
- Both request continuously for 6 transactions → grants alternate 01,10,01,10,01,10; no requester is starved.
- TIMEOUT=16, memory never asserts DataRdy → err_timeout=1 after 16 BUSY cycles; state IDLE; a subsequent m1 request is granted.
- m1 drives oe=we=1 → err_conflict=1 and sticks until reset; the transaction still completes.
- reset pulsed low during BUSY → Mout_oe/we=0 within the same cycle; grant=00; after release, m0 has priority.
